// File: rtl/gx4000_sfx_mixer.sv
// -----------------------------------------------------------------------------
// gx4000_sfx_mixer
//
// Multi-channel sound-effect synthesiser and mixer for the GX4000/Plus audio
// path. NUM_CH tone channels, each with a phase accumulator, frequency word,
// volume and pan, are programmed through CPU page 0xBCxx. On every sample
// strobe the channels are scanned one per clock and added onto the CPC PSG
// audio. The sum is saturated and registered as the stereo output.
//
// Optional build macro:
//   GX_SFX_NOISE_EN - adds a 17-bit LFSR noise source to channel NUM_CH-1,
//                     selected per sample by ctrl bit3 of that channel.
//
// Ports:
//   clk_sys       in   system clock
//   reset         in   synchronous active-high reset
//   plus_mode     in   1 = mixer active, 0 = CPC audio passes straight through
//   cpu_addr      in   CPU address (16 bits)
//   cpu_data      in   CPU write data (8 bits)
//   cpu_wr        in   write strobe, one clk_sys per access
//   sample_ce     in   one-cycle sample-rate strobe
//   cpc_audio_l   in   CPC left sample  (SAMPLE_W)
//   cpc_audio_r   in   CPC right sample (SAMPLE_W)
//   audio_l       out  mixed left output  (SAMPLE_W)
//   audio_r       out  mixed right output (SAMPLE_W)
//   audio_status  out  {en[3:0] of ch0-3, 2'b0, overrun, busy}
//
// Register map (page 0xBC, offset o = addr[7:0] - BASE_ADDR):
//   ch = o/4, r = o%4 : r0 freq[7:0], r1 freq[ACC_W-1:8], r2 volume, r3 ctrl
//   ctrl: bit0 en, bits2:1 pan (00 both, 01 left, 10 right, 11 both at vol/2)
//   o == 4*NUM_CH     : any write clears the sticky overrun flag
//
// Handshake: sample_ce is a single-cycle pulse with no ready; a pulse that
// arrives while the scan is in progress (busy) is dropped and flagged as
// overrun.
// -----------------------------------------------------------------------------
module gx4000_sfx_mixer #(
   parameter int         NUM_CH    = 4,
   parameter int         SAMPLE_W  = 8,
   parameter int         ACC_W     = 16,
   parameter logic [7:0] BASE_ADDR = 8'hE0
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                plus_mode,
   input  logic [15:0]         cpu_addr,
   input  logic [7:0]          cpu_data,
   input  logic                cpu_wr,
   input  logic                sample_ce,
   input  logic [SAMPLE_W-1:0] cpc_audio_l,
   input  logic [SAMPLE_W-1:0] cpc_audio_r,
   output logic [SAMPLE_W-1:0] audio_l,
   output logic [SAMPLE_W-1:0] audio_r,
   output logic [7:0]          audio_status
);

   // Wide enough for the CPC sample plus NUM_CH full-volume channels.
   localparam int ACC_SUM_W = SAMPLE_W + $clog2(NUM_CH + 1);
   localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);
   localparam logic [5:0]       NUM_CH_L   = 6'(NUM_CH);
   localparam logic [7:0]       OVR_CLR_OFF = 8'(4 * NUM_CH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   // ---------------------------------------------------------------------
   // Channel registers
   // ---------------------------------------------------------------------
   logic [ACC_W-1:0]    freq_q  [NUM_CH];
   logic [SAMPLE_W-1:0] vol_q   [NUM_CH];
   logic [1:0]          pan_q   [NUM_CH];
   logic [ACC_W-1:0]    phase_q [NUM_CH];
   logic [NUM_CH-1:0]   en_q;
`ifdef GX_SFX_NOISE_EN
   logic [NUM_CH-1:0]   noise_q;
   logic [16:0]         lfsr_q;
`endif

   logic [1:0]           state_q;
   logic [IDX_W-1:0]     idx_q;
   logic [ACC_SUM_W-1:0] acc_l_q;
   logic [ACC_SUM_W-1:0] acc_r_q;
   logic [SAMPLE_W-1:0]  cpc_l_q;
   logic [SAMPLE_W-1:0]  cpc_r_q;
   logic                 overrun_q;
   logic                 busy;

   // ---------------------------------------------------------------------
   // CPU register decode
   // ---------------------------------------------------------------------
   logic             page_wr;
   logic [7:0]       reg_off;
   logic [5:0]       reg_ch;
   logic [1:0]       reg_sel;
   logic             ch_wr;
   logic             ctrl_wr;
   logic             ovr_clr;
   logic [IDX_W-1:0] wr_ch;

   assign page_wr = cpu_wr && (cpu_addr[15:8] == 8'hBC);
   assign reg_off = cpu_addr[7:0] - BASE_ADDR;   // wraps below BASE_ADDR, so those offsets fall out of range
   assign reg_ch  = reg_off[7:2];
   assign reg_sel = reg_off[1:0];
   assign ch_wr   = page_wr && (reg_ch < NUM_CH_L);
   assign ctrl_wr = ch_wr && (reg_sel == 2'd3);
   assign ovr_clr = page_wr && (reg_off == OVR_CLR_OFF);
   assign wr_ch   = IDX_W'(reg_ch);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            freq_q[i] <= '0;
            vol_q[i]  <= '0;
            pan_q[i]  <= '0;
         end
         en_q <= '0;
`ifdef GX_SFX_NOISE_EN
         noise_q <= '0;
`endif
      end else if (ch_wr) begin
         case (reg_sel)
            2'd0: freq_q[wr_ch][7:0]       <= cpu_data;
            2'd1: freq_q[wr_ch][ACC_W-1:8] <= cpu_data[ACC_W-9:0];
            2'd2: vol_q[wr_ch]             <= SAMPLE_W'(cpu_data);
            default: begin
               en_q[wr_ch]  <= cpu_data[0];
               pan_q[wr_ch] <= cpu_data[2:1];
`ifdef GX_SFX_NOISE_EN
               noise_q[wr_ch] <= cpu_data[3];
`endif
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Scan datapath for the channel selected by idx_q. Registers are read
   // before any same-cycle CPU write lands, so a write during a channel's
   // scan slot only takes effect on the next sample.
   // ---------------------------------------------------------------------
   logic [ACC_W-1:0]     cur_phase;
   logic [ACC_W-1:0]     cur_freq;
   logic [SAMPLE_W-1:0]  cur_vol;
   logic [1:0]           cur_pan;
   logic                 cur_en;
   logic [ACC_W-1:0]     new_phase;
   logic [SAMPLE_W-1:0]  amp;
   logic [ACC_SUM_W-1:0] amp_full;
   logic [ACC_SUM_W-1:0] amp_half;
   logic [ACC_SUM_W-1:0] add_l;
   logic [ACC_SUM_W-1:0] add_r;
   logic                 scan_adv;
`ifdef GX_SFX_NOISE_EN
   logic                 phase_wrap;
   logic                 noise_ch;
`endif

   assign cur_phase = phase_q[idx_q];
   assign cur_freq  = freq_q[idx_q];
   assign cur_vol   = vol_q[idx_q];
   assign cur_pan   = pan_q[idx_q];
   assign cur_en    = en_q[idx_q];
   assign scan_adv  = (state_q == ST_SCAN) && cur_en;

`ifdef GX_SFX_NOISE_EN
   assign {phase_wrap, new_phase} = {1'b0, cur_phase} + {1'b0, cur_freq};
   assign noise_ch = (idx_q == LAST_IDX);
`else
   assign new_phase = cur_phase + cur_freq;
`endif

   always_comb begin
      amp = '0;
      if (cur_en) begin
`ifdef GX_SFX_NOISE_EN
         if (noise_ch && noise_q[idx_q]) begin
            amp = lfsr_q[0] ? cur_vol : '0;
         end else begin
            amp = new_phase[ACC_W-1] ? cur_vol : '0;
         end
`else
         amp = new_phase[ACC_W-1] ? cur_vol : '0;
`endif
      end
   end

   assign amp_full = ACC_SUM_W'(amp);
   assign amp_half = amp_full >> 1;

   always_comb begin
      add_l = '0;
      add_r = '0;
      case (cur_pan)
         2'b00: begin add_l = amp_full; add_r = amp_full; end
         2'b01: begin add_l = amp_full; end
         2'b10: begin add_r = amp_full; end
         default: begin add_l = amp_half; add_r = amp_half; end
      endcase
   end

   // Phase accumulators. Disabling a channel through its ctrl register
   // restarts it from phase 0 and overrides a scan update in the same cycle.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            phase_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ctrl_wr && (wr_ch == IDX_W'(i)) && !cpu_data[0]) begin
               phase_q[i] <= '0;
            end else if (scan_adv && (idx_q == IDX_W'(i))) begin
               phase_q[i] <= new_phase;
            end
         end
      end
   end

`ifdef GX_SFX_NOISE_EN
   // 17-bit Fibonacci LFSR, taps 17 and 14, stepped on each phase wrap of
   // the last channel.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         lfsr_q <= 17'd1;
      end else if (scan_adv && noise_ch && phase_wrap) begin
         lfsr_q <= {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Sequencer: IDLE -> SCAN (NUM_CH cycles) -> OUT -> IDLE
   // ---------------------------------------------------------------------
   function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_SUM_W-1:0] v);
      if (|v[ACC_SUM_W-1:SAMPLE_W]) begin
         return '1;
      end
      return v[SAMPLE_W-1:0];
   endfunction

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         cpc_l_q <= '0;
         cpc_r_q <= '0;
         audio_l <= '0;
         audio_r <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sample_ce) begin
                  acc_l_q <= ACC_SUM_W'(cpc_audio_l);
                  acc_r_q <= ACC_SUM_W'(cpc_audio_r);
                  cpc_l_q <= cpc_audio_l;
                  cpc_r_q <= cpc_audio_r;
                  idx_q   <= '0;
                  state_q <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               acc_l_q <= acc_l_q + add_l;
               acc_r_q <= acc_r_q + add_r;
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_OUT;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_OUT: begin
               // Pass-through still runs the scan so phases keep advancing;
               // only the output selection changes.
               if (plus_mode) begin
                  audio_l <= saturate(acc_l_q);
                  audio_r <= saturate(acc_r_q);
               end else begin
                  audio_l <= cpc_l_q;
                  audio_r <= cpc_r_q;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_SCAN) || (state_q == ST_OUT);

   // Sticky overrun: a new strobe wins over a simultaneous clear so the
   // event is never lost.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         overrun_q <= 1'b0;
      end else if (sample_ce && busy) begin
         overrun_q <= 1'b1;
      end else if (ovr_clr) begin
         overrun_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Status
   // ---------------------------------------------------------------------
   logic [3:0] en_nib;

   for (genvar g = 0; g < 4; g++) begin : g_en_nib
      if (g < NUM_CH) begin : g_present
         assign en_nib[g] = en_q[g];
      end else begin : g_absent
         assign en_nib[g] = 1'b0;
      end
   end

   assign audio_status = {en_nib, 2'b00, overrun_q, busy};

endmodule

// File: tb/tb_gx4000_sfx_mixer.sv
// -----------------------------------------------------------------------------
// tb_gx4000_sfx_mixer
//
// Directed bench for gx4000_sfx_mixer in its default build (NUM_CH=4,
// SAMPLE_W=8, ACC_W=16, BASE_ADDR=0xE0). Each task drives one scenario and
// checks hand-computed expected values inline.
// -----------------------------------------------------------------------------
module tb_gx4000_sfx_mixer;

   localparam int NUM_CH = 4;

   logic        clk_sys;
   logic        reset;
   logic        plus_mode;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_wr;
   logic        sample_ce;
   logic [7:0]  cpc_audio_l;
   logic [7:0]  cpc_audio_r;
   logic [7:0]  audio_l;
   logic [7:0]  audio_r;
   logic [7:0]  audio_status;

   int checks = 0;
   int errors = 0;

   gx4000_sfx_mixer #(
      .NUM_CH   (NUM_CH),
      .SAMPLE_W (8),
      .ACC_W    (16),
      .BASE_ADDR(8'hE0)
   ) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .plus_mode   (plus_mode),
      .cpu_addr    (cpu_addr),
      .cpu_data    (cpu_data),
      .cpu_wr      (cpu_wr),
      .sample_ce   (sample_ce),
      .cpc_audio_l (cpc_audio_l),
      .cpc_audio_r (cpc_audio_r),
      .audio_l     (audio_l),
      .audio_r     (audio_r),
      .audio_status(audio_status)
   );

   // ---------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // ---------------------------------------------------------------------
   // Driver tasks: inputs change 1 ns after the rising edge and outputs are
   // sampled at the same point, well away from the active edge.
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
      cpu_addr = addr;
      cpu_data = data;
      cpu_wr   = 1'b1;
      tick();
      cpu_wr   = 1'b0;
   endtask

   task automatic write_reg(input int ch, input int r, input logic [7:0] data);
      logic [15:0] addr;
      addr = 16'hBCE0 + 16'(4 * ch + r);
      cpu_write(addr, data);
   endtask

   // One complete sample: strobe, then wait until the output edge.
   task automatic run_sample(input logic [7:0] cl, input logic [7:0] cr);
      cpc_audio_l = cl;
      cpc_audio_r = cr;
      sample_ce   = 1'b1;
      tick();
      sample_ce   = 1'b0;
      repeat (NUM_CH + 1) tick();
   endtask

   task automatic check_out(input string name, input logic [7:0] exp_l, input logic [7:0] exp_r);
      checks++;
      if (audio_l !== exp_l) begin
         errors++;
         $display("FAIL %s audio_l: got %02h expected %02h", name, audio_l, exp_l);
      end
      checks++;
      if (audio_r !== exp_r) begin
         errors++;
         $display("FAIL %s audio_r: got %02h expected %02h", name, audio_r, exp_r);
      end
   endtask

   task automatic check_status(input string name, input logic [7:0] exp_s);
      checks++;
      if (audio_status !== exp_s) begin
         errors++;
         $display("FAIL %s audio_status: got %02h expected %02h", name, audio_status, exp_s);
      end
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_out("reset", 8'h00, 8'h00);
      check_status("reset", 8'h00);
      // No channels enabled: output equals the CPC sample, NUM_CH+1 edges later.
      cpc_audio_l = 8'h12;
      cpc_audio_r = 8'h34;
      sample_ce   = 1'b1;
      tick();
      sample_ce   = 1'b0;
      repeat (NUM_CH) tick();
      check_out("latency_early", 8'h00, 8'h00);
      tick();
      check_out("latency", 8'h12, 8'h34);
   endtask

   task automatic test_square();
      write_reg(0, 0, 8'h00);
      write_reg(0, 1, 8'h80);
      write_reg(0, 2, 8'h40);
      write_reg(0, 3, 8'h01);
      check_status("square_en", 8'h10);
      run_sample(8'h00, 8'h00);
      check_out("square_1", 8'h40, 8'h40);
      run_sample(8'h00, 8'h00);
      check_out("square_2", 8'h00, 8'h00);
      run_sample(8'h00, 8'h00);
      check_out("square_3", 8'h40, 8'h40);
      run_sample(8'h00, 8'h00);
      check_out("square_4", 8'h00, 8'h00);
   endtask

   task automatic test_sat_pan();
      // ch0 phase is 0 here; left-only pan, 0xF0 + 0x40 saturates.
      write_reg(0, 3, 8'h03);
      run_sample(8'hF0, 8'h11);
      check_out("sat_left", 8'hFF, 8'h11);
      // ch1 at half volume on both sides; ch0 phase wraps to 0 (silent).
      write_reg(1, 0, 8'h00);
      write_reg(1, 1, 8'h80);
      write_reg(1, 2, 8'h40);
      write_reg(1, 3, 8'h07);
      run_sample(8'h10, 8'h20);
      check_out("pan_half", 8'h30, 8'h40);
      // ch0 right-only, high half; ch1 silent this sample.
      write_reg(0, 3, 8'h05);
      run_sample(8'h10, 8'h20);
      check_out("pan_right", 8'h10, 8'h60);
      check_status("pan_en", 8'h30);
      write_reg(0, 3, 8'h00);
      write_reg(1, 3, 8'h00);
      check_status("pan_off", 8'h00);
   endtask

   task automatic test_overrun();
      cpc_audio_l = 8'h00;
      cpc_audio_r = 8'h00;
      sample_ce   = 1'b1;
      tick();
      check_status("busy", 8'h01);
      tick();
      sample_ce   = 1'b0;
      check_status("overrun_set", 8'h03);
      repeat (NUM_CH) tick();
      check_status("overrun_sticky", 8'h02);
      cpu_write(16'hBCF1, 8'h00);        // neighbouring offset, must not clear
      check_status("overrun_keep", 8'h02);
      cpu_write(16'hBDF0, 8'h00);        // wrong page
      check_status("overrun_page", 8'h02);
      cpu_write(16'hBCF0, 8'h5A);
      check_status("overrun_clr", 8'h00);
   endtask

   task automatic test_disable();
      write_reg(2, 0, 8'h00);
      write_reg(2, 1, 8'h80);
      write_reg(2, 2, 8'h20);
      write_reg(2, 3, 8'h01);
      check_status("dis_en", 8'h40);
      // Strobe, then land ctrl=0 on the edge that scans ch2 (third scan edge).
      cpc_audio_l = 8'h00;
      cpc_audio_r = 8'h00;
      sample_ce   = 1'b1;
      tick();
      sample_ce   = 1'b0;
      tick();
      tick();
      write_reg(2, 3, 8'h00);
      tick();
      tick();
      check_out("dis_old_value", 8'h20, 8'h20);
      check_status("dis_status", 8'h00);
      run_sample(8'h00, 8'h00);
      check_out("dis_silent", 8'h00, 8'h00);
      // Re-enabled from a cleared phase: 0 -> 0x8000 gives a high half.
      write_reg(2, 3, 8'h01);
      run_sample(8'h00, 8'h00);
      check_out("dis_phase_clr", 8'h20, 8'h20);
      write_reg(2, 3, 8'h00);
   endtask

   task automatic test_passthrough();
      write_reg(0, 3, 8'h01);            // ch0 phase 0, freq 0x8000, vol 0x40
      plus_mode = 1'b0;
      run_sample(8'h55, 8'h66);
      check_out("pass_cpc", 8'h55, 8'h66);
      plus_mode = 1'b1;
      // Phase advanced during pass-through, so this sample is the low half.
      run_sample(8'h55, 8'h66);
      check_out("pass_phase_adv", 8'h55, 8'h66);
      run_sample(8'h55, 8'h66);
      check_out("pass_mix", 8'h95, 8'hA6);
   endtask

   task automatic test_decode();
      cpu_write(16'hBDE3, 8'h01);        // ch1 ctrl on wrong page
      cpu_write(16'hBCF4, 8'h01);        // beyond last channel
      cpu_write(16'hBCDF, 8'h01);        // below base
      check_status("decode_ignored", 8'h10);
      write_reg(3, 3, 8'h01);
      check_status("decode_ch3", 8'h90);
   endtask

   task automatic test_reset_mid_scan();
      sample_ce   = 1'b1;
      cpc_audio_l = 8'h77;
      cpc_audio_r = 8'h88;
      tick();
      sample_ce   = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_out("rst_mid", 8'h00, 8'h00);
      check_status("rst_mid", 8'h00);
      repeat (NUM_CH + 2) tick();
      check_out("rst_mid_late", 8'h00, 8'h00);
   endtask

   // ---------------------------------------------------------------------
   // Main sequence and report
   // ---------------------------------------------------------------------
   initial begin
      reset       = 1'b1;
      plus_mode   = 1'b1;
      cpu_addr    = 16'h0000;
      cpu_data    = 8'h00;
      cpu_wr      = 1'b0;
      sample_ce   = 1'b0;
      cpc_audio_l = 8'h00;
      cpc_audio_r = 8'h00;

      test_reset();
      test_square();
      test_sat_pan();
      test_overrun();
      test_disable();
      test_passthrough();
      test_decode();
      test_reset_mid_scan();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
